// File: rtl/mor1kx_avalon_pkg.sv
// mor1kx_avalon_pkg: shared state encodings, Avalon response codes and clog2 helper
package mor1kx_avalon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_READ  = 4'b0010,
        ST_WRITE = 4'b0100,
        ST_DRAIN = 4'b1000
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_RSVD   = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mor1kx_avalon_beat_counter.sv
// mor1kx_avalon_beat_counter: loadable beat down-counter flagging the final beat
module mor1kx_avalon_beat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign last_o = cnt_q == W'(1);

endmodule

// File: rtl/mor1kx_bus_if_avalon_burst.sv
// mor1kx_bus_if_avalon_burst: mor1kx CPU bus to Avalon-MM burst master bridge
// with beat-counted bursts, response-to-error mapping and optional read timeout.
module mor1kx_bus_if_avalon_burst
    import mor1kx_avalon_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_LENGTH   = 4,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int BCW           = clog2(BURST_LENGTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic                    cpu_burst_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
    output logic                    cpu_ack_o,
    output logic                    cpu_err_o,
    output logic [DATA_WIDTH-1:0]   cpu_dat_o,
    output logic [ADDR_WIDTH-1:0]   avm_address_o,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable_o,
    output logic                    avm_read_o,
    output logic                    avm_write_o,
    output logic [DATA_WIDTH-1:0]   avm_writedata_o,
    output logic [BCW-1:0]          avm_burstcount_o,
    input  logic [DATA_WIDTH-1:0]   avm_readdata_i,
    input  logic                    avm_waitrequest_i,
    input  logic                    avm_readdatavalid_i,
    input  logic [1:0]              avm_response_i
);

    localparam int TW = clog2(TIMEOUT_CYCLES + 1) + 1;

    state_t          st_q, st_d;
    logic            wr_ack_q, wr_ack_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            ld, dec, last;
    logic [BCW-1:0]  ld_val;
    logic            in_idle, in_read, rd_busy, rd_acc, wr_acc, resp_ok, tmo_hit;

    assign in_idle = st_q == ST_IDLE;
    assign in_read = st_q == ST_READ;
    assign rd_busy = in_read | (st_q == ST_DRAIN);
    assign resp_ok = avm_response_i == RESP_OKAY;

    // Commands are gated by rst_n so they drop the moment reset is asserted.
    assign avm_read_o  = rst_n & cpu_req_i & ~cpu_we_i & in_idle & ~wr_ack_q;
    assign avm_write_o = rst_n & cpu_req_i & cpu_we_i & ~wr_ack_q & (in_idle | st_q == ST_WRITE);
    assign avm_burstcount_o = (in_idle & cpu_burst_i) ? BCW'(BURST_LENGTH) : BCW'(1);
    assign rd_acc = avm_read_o & ~avm_waitrequest_i;
    assign wr_acc = avm_write_o & ~avm_waitrequest_i;

    assign avm_address_o    = cpu_adr_i;
    assign avm_byteenable_o = cpu_bsel_i;
    assign avm_writedata_o  = cpu_dat_i;
    assign cpu_dat_o        = avm_readdata_i;

    assign tmo_hit   = (TIMEOUT_CYCLES > 0) && rd_busy && !avm_readdatavalid_i && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign cpu_ack_o = (in_read & avm_readdatavalid_i & resp_ok) | wr_ack_q;
    assign cpu_err_o = in_read & ((avm_readdatavalid_i & ~resp_ok) | tmo_hit);

    always_comb begin
        st_d     = st_q;
        wr_ack_d = 1'b0;
        ld       = 1'b0;
        ld_val   = '0;
        dec      = 1'b0;
        tmo_d    = '0;
        unique case (st_q)
            ST_IDLE: begin
                if (rd_acc) begin
                    st_d   = ST_READ;
                    ld     = 1'b1;
                    ld_val = cpu_burst_i ? BCW'(BURST_LENGTH) : BCW'(1);
                end else if (wr_acc) begin
                    wr_ack_d = 1'b1;
                    st_d     = cpu_burst_i ? ST_WRITE : ST_IDLE;
                    ld       = cpu_burst_i;
                    ld_val   = BCW'(BURST_LENGTH - 1);
                end
            end
            ST_READ, ST_DRAIN: begin
                dec   = avm_readdatavalid_i;
                tmo_d = avm_readdatavalid_i ? '0 : tmo_q + 1'b1;
                if (avm_readdatavalid_i)
                    st_d = last ? ST_IDLE : (in_read && !resp_ok) ? ST_DRAIN : st_q;
                else if (tmo_hit)
                    st_d = ST_IDLE;
            end
            ST_WRITE: begin
                dec      = wr_acc;
                wr_ack_d = wr_acc;
                st_d     = (wr_acc && last) ? ST_IDLE : ST_WRITE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            wr_ack_q <= 1'b0;
            tmo_q    <= '0;
        end else begin
            st_q     <= st_d;
            wr_ack_q <= wr_ack_d;
            tmo_q    <= tmo_d;
        end
    end

    mor1kx_avalon_beat_counter #(.W(BCW)) u_beats (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ld),
        .load_val_i (ld_val),
        .dec_i      (dec),
        .last_o     (last)
    );

endmodule

// File: tb/tb_mor1kx_bus_if_avalon_burst.sv
// tb_mor1kx_bus_if_avalon_burst: directed checks of reads, bursts, errors, timeout and reset
module tb_mor1kx_bus_if_avalon_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0, cpu_burst_i = 1'b0;
    logic [31:0] cpu_adr_i = '0, cpu_dat_i = '0;
    logic [3:0]  cpu_bsel_i = '0;
    logic        cpu_ack_o, cpu_err_o;
    logic [31:0] cpu_dat_o, avm_address_o, avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_read_o, avm_write_o;
    logic [2:0]  avm_burstcount_o;
    logic [31:0] avm_readdata_i = '0;
    logic        avm_waitrequest_i = 1'b0, avm_readdatavalid_i = 1'b0;
    logic [1:0]  avm_response_i = 2'b00;

    int n_chk = 0;
    int n_pass = 0;

    mor1kx_bus_if_avalon_burst #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LENGTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cpu_req_i           (cpu_req_i),
        .cpu_we_i            (cpu_we_i),
        .cpu_burst_i         (cpu_burst_i),
        .cpu_adr_i           (cpu_adr_i),
        .cpu_dat_i           (cpu_dat_i),
        .cpu_bsel_i          (cpu_bsel_i),
        .cpu_ack_o           (cpu_ack_o),
        .cpu_err_o           (cpu_err_o),
        .cpu_dat_o           (cpu_dat_o),
        .avm_address_o       (avm_address_o),
        .avm_byteenable_o    (avm_byteenable_o),
        .avm_read_o          (avm_read_o),
        .avm_write_o         (avm_write_o),
        .avm_writedata_o     (avm_writedata_o),
        .avm_burstcount_o    (avm_burstcount_o),
        .avm_readdata_i      (avm_readdata_i),
        .avm_waitrequest_i   (avm_waitrequest_i),
        .avm_readdatavalid_i (avm_readdatavalid_i),
        .avm_response_i      (avm_response_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        #3;
    endtask

    task automatic rcmd(input logic b, input logic [2:0] bc);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_burst_i = b; avm_waitrequest_i = 1'b0;
        look;
        chk("rcmd_read", avm_read_o, 1'b1);
        chk("rcmd_bc", avm_burstcount_o, bc);
        tick;
        cpu_req_i = 1'b0; cpu_burst_i = 1'b0;
    endtask

    task automatic rbeat(input logic [31:0] d, input logic [1:0] resp, input logic ea, input logic ee);
        avm_readdatavalid_i = 1'b1; avm_readdata_i = d; avm_response_i = resp;
        look;
        chk("rbeat_ack", cpu_ack_o, ea);
        chk("rbeat_err", cpu_err_o, ee);
        if (ea) chk("rbeat_dat", cpu_dat_o, d);
        tick;
        avm_readdatavalid_i = 1'b0; avm_response_i = 2'b00;
    endtask

    task automatic gap;
        look;
        chk("gap_ack", cpu_ack_o, 1'b0);
        chk("gap_err", cpu_err_o, 1'b0);
        tick;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic b, input logic [2:0] bc, input int nw);
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_burst_i = b; cpu_dat_i = d;
        repeat (nw) begin
            avm_waitrequest_i = 1'b1;
            look;
            chk("wstall_write", avm_write_o, 1'b1);
            chk("wstall_ack", cpu_ack_o, 1'b0);
            tick;
        end
        avm_waitrequest_i = 1'b0;
        look;
        chk("wacc_write", avm_write_o, 1'b1);
        chk("wacc_data", avm_writedata_o, d);
        chk("wacc_bc", avm_burstcount_o, bc);
        chk("wacc_ack", cpu_ack_o, 1'b0);
        tick;
        cpu_burst_i = 1'b0;
        look;
        chk("wack_ack", cpu_ack_o, 1'b1);
        chk("wack_write", avm_write_o, 1'b0);
        tick;
    endtask

    initial begin
        int nrd;
        // Reset: commands gated, datapath passes through
        cpu_req_i = 1'b1; cpu_adr_i = 32'h100; cpu_bsel_i = 4'hA; cpu_dat_i = 32'h1234;
        avm_readdata_i = 32'h5678;
        tick; tick;
        look;
        chk("rst_read", avm_read_o, 1'b0);
        chk("rst_write", avm_write_o, 1'b0);
        chk("rst_ack", cpu_ack_o, 1'b0);
        chk("rst_err", cpu_err_o, 1'b0);
        chk("rst_adr", avm_address_o, 32'h100);
        chk("rst_be", avm_byteenable_o, 4'hA);
        chk("rst_wdat", avm_writedata_o, 32'h1234);
        chk("rst_rdat", cpu_dat_o, 32'h5678);
        chk("rst_bc", avm_burstcount_o, 3'd1);
        tick;
        rst_n = 1'b1; cpu_req_i = 1'b0; cpu_bsel_i = 4'hF;
        tick;

        // 1: single read, 2 wait states, data 3 cycles after acceptance
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h1000;
        nrd = 0;
        for (int i = 0; i < 3; i++) begin
            avm_waitrequest_i = (i < 2);
            look;
            nrd += int'(avm_read_o);
            if (i == 0) chk("t1_bc", avm_burstcount_o, 3'd1);
            tick;
        end
        avm_waitrequest_i = 1'b0;
        chk("t1_read_cycles", nrd, 3);
        for (int i = 0; i < 2; i++) begin
            look;
            chk("t1_no_reissue", avm_read_o, 1'b0);
            chk("t1_no_ack", cpu_ack_o, 1'b0);
            tick;
        end
        rbeat(32'hDEADBEEF, 2'b00, 1'b1, 1'b0);
        avm_waitrequest_i = 1'b1;
        look;
        chk("t1_idle", avm_read_o, 1'b1);
        tick;
        cpu_req_i = 1'b0; avm_waitrequest_i = 1'b0;

        // 2: read burst, burst hint dropped after command
        rcmd(1'b1, 3'd4);
        cpu_req_i = 1'b1;
        look;
        chk("t2_no_reissue", avm_read_o, 1'b0);
        chk("t2_bc_after", avm_burstcount_o, 3'd1);
        tick;
        for (int i = 0; i < 4; i++) begin
            rbeat(32'hA0 + i, 2'b00, 1'b1, 1'b0);
            if (i < 3) gap;
        end
        cpu_req_i = 1'b0;
        gap;

        // 3: write burst 1..4 with varying stalls
        wbeat(32'h1, 1'b1, 3'd4, 1);
        wbeat(32'h2, 1'b0, 3'd1, 1);
        wbeat(32'h3, 1'b0, 3'd1, 0);
        wbeat(32'h4, 1'b0, 3'd1, 2);
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        gap;
        cpu_req_i = 1'b1; avm_waitrequest_i = 1'b1;
        look;
        chk("t3_idle", avm_read_o, 1'b1);
        tick;
        cpu_req_i = 1'b0; avm_waitrequest_i = 1'b0;

        // 4: SLVERR on beat 2, remaining beats drained silently
        rcmd(1'b1, 3'd4);
        rbeat(32'h11, 2'b00, 1'b1, 1'b0);
        rbeat(32'h22, 2'b10, 1'b0, 1'b1);
        cpu_req_i = 1'b1;
        look;
        chk("t4_drain_noread", avm_read_o, 1'b0);
        tick;
        rbeat(32'h33, 2'b00, 1'b0, 1'b0);
        rbeat(32'h44, 2'b00, 1'b0, 1'b0);
        rcmd(1'b0, 3'd1);
        rbeat(32'h77, 2'b00, 1'b1, 1'b0);

        // 5: timeout 8 cycles after acceptance, late beat ignored
        rcmd(1'b0, 3'd1);
        for (int k = 1; k <= 8; k++) begin
            look;
            chk($sformatf("t5_err_c%0d", k), cpu_err_o, k == 8);
            chk("t5_ack", cpu_ack_o, 1'b0);
            tick;
        end
        rbeat(32'h99, 2'b00, 1'b0, 1'b0);

        // 6: async reset during beat 2 of a write burst
        wbeat(32'h1, 1'b1, 3'd4, 0);
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_dat_i = 32'h2; avm_waitrequest_i = 1'b1;
        look;
        chk("t6_pre_write", avm_write_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_write", avm_write_o, 1'b0);
        chk("t6_rst_ack", cpu_ack_o, 1'b0);
        chk("t6_rst_read", avm_read_o, 1'b0);
        tick; tick;
        rst_n = 1'b1; cpu_we_i = 1'b0;
        look;
        chk("t6_idle", avm_read_o, 1'b1);
        chk("t6_no_ack", cpu_ack_o, 1'b0);
        tick;
        wbeat(32'h55, 1'b0, 3'd1, 0);
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        look;
        chk("t6_done_ack", cpu_ack_o, 1'b0);
        chk("t6_done_write", avm_write_o, 1'b0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mor1kx_bus_if_avalon_burst.md
Name: mor1kx_bus_if_avalon_burst

Overview:
Parametrised Avalon-MM master bridge between the mor1kx CPU bus (cpu_*) and an Avalon-MM interconnect (avm_*). It supports configurable data/address width and burst length, and both read bursts and write bursts. Beats are counted internally, so bursts end on a beat count and do not depend on the CPU's burst hint. Avalon read responses are propagated as cpu_err_o, and an optional read-response timeout converts a hung slave into a bus error. It sits between the CPU fetch/LSU bus ports and the system Avalon fabric.

Parameters:
DATA_WIDTH, 32, CPU/Avalon data width; must be a multiple of 8.
ADDR_WIDTH, 32, address width; passed through unchanged.
BURST_LENGTH, 4, beats per burst; must be a power of two, 2..16.
TIMEOUT_CYCLES, 0, read-response timeout in cycles; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_req_i  in  1  request
cpu_we_i  in  1  write enable
cpu_burst_i  in  1  burst request; sampled only on the first beat
cpu_adr_i  in  ADDR_WIDTH  address
cpu_dat_i  in  DATA_WIDTH  write data
cpu_bsel_i  in  DATA_WIDTH/8  byte select
cpu_ack_o  out  1  beat complete
cpu_err_o  out  1  beat failed
cpu_dat_o  out  DATA_WIDTH  read data
avm_address_o  out  ADDR_WIDTH  equals cpu_adr_i
avm_byteenable_o  out  DATA_WIDTH/8  equals cpu_bsel_i
avm_read_o  out  1  read command
avm_write_o  out  1  write command
avm_writedata_o  out  DATA_WIDTH  equals cpu_dat_i
avm_burstcount_o  out  BCW  BCW = clog2(BURST_LENGTH)+1
avm_waitrequest_i  in  1  slave stall
avm_readdatavalid_i  in  1  read beat valid
avm_response_i  in  2  read response; 00 means OKAY

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, beats_left=0, wr_ack_q=0, tmo_cnt=0.
  - All command and ack outputs are 0; datapath outputs pass through.
- States: IDLE, READ, WRITE, DRAIN (one-hot encoding).
- avm_read_o = cpu_req_i & !cpu_we_i & state==IDLE & !wr_ack_q.
- avm_write_o = cpu_req_i & cpu_we_i & !wr_ack_q & (state==IDLE | state==WRITE).
- avm_burstcount_o = BURST_LENGTH when state==IDLE & cpu_burst_i, else 1.
- Command acceptance: a command is accepted in any cycle where it is asserted and avm_waitrequest_i=0.
- IDLE, read accepted:
  - Go to READ; beats_left = burst ? BURST_LENGTH : 1; tmo_cnt=0.
- IDLE, write accepted:
  - wr_ack_q<=1.
  - If burst: go to WRITE with beats_left=BURST_LENGTH-1.
  - Otherwise stay in IDLE.
- READ:
  - Each avm_readdatavalid_i: beats_left decrements; tmo_cnt clears.
  - Response OKAY: cpu_ack_o=1 combinationally in the same cycle.
  - Response non-OKAY: cpu_err_o=1 and cpu_ack_o=0. If beats_left>1, go to DRAIN; otherwise go to IDLE.
  - Last OKAY beat (beats_left==1): go to IDLE.
- DRAIN:
  - Consume the remaining readdatavalid beats with no ack and no err.
  - Go to IDLE on the last beat.
- WRITE:
  - Each accepted beat decrements beats_left and sets wr_ack_q.
  - Transition to IDLE on the beat that takes beats_left to 0.
  - avm_write_o is low during the wr_ack_q cycle. This is a legal Avalon write-burst bubble and lets the CPU present the next beat.
- cpu_ack_o = (READ OKAY beat) | wr_ack_q. wr_ack_q is a 1-cycle pulse, giving write ack latency of 1 cycle after acceptance.
- Timeout (TIMEOUT_CYCLES>0):
  - In READ/DRAIN, tmo_cnt increments every cycle without readdatavalid.
  - On reaching TIMEOUT_CYCLES: cpu_err_o pulses for 1 cycle (READ only; silent in DRAIN), then go to IDLE.
  - Late beats arriving in IDLE are ignored (no ack, no err).
- cpu_err_o and cpu_ack_o are never high in the same cycle.
- cpu_dat_o = avm_readdata_i, unregistered.
- Reset mid-burst: immediate return to IDLE; no further ack; in-flight beats after reset are ignored.
- cpu_burst_i deassertion mid-burst does not shorten the burst; beat count rules.

Decomposition:
- Shared package mor1kx_avalon_pkg holds:
  - state encodings;
  - the response codes (OKAY=00, RSVD=01, SLVERR=10, DECERR=11);
  - a clog2 function.
- One natural sub-module: mor1kx_avalon_beat_counter, a loadable down-counter with last-beat flag, shared by READ/WRITE/DRAIN.

Test Plan:
1. Single read: req, we=0, burst=0, waitrequest high 2 cycles, readdatavalid 3 cycles later with data 0xDEADBEEF -> avm_read_o high 3 cycles, burstcount=1, one cpu_ack_o with cpu_dat_o=0xDEADBEEF, back to IDLE.
2. Read burst BURST_LENGTH=4, cpu_burst_i dropped after beat 1 -> burstcount=4 on command only, exactly 4 acks, no second command issued.
3. Write burst of 4 beats, waitrequest toggling -> 4 accepted beats with data 0x1..0x4 in order, burstcount=4 on first beat only, 4 acks each 1 cycle after acceptance, no write during ack cycles.
4. Read burst with response=10 on beat 2 -> ack on beat 1, err (no ack) on beat 2, beats 3–4 drained silently, then a new read is accepted.
5. TIMEOUT_CYCLES=8, no readdatavalid -> cpu_err_o pulse exactly 8 cycles after acceptance; a late readdatavalid produces no ack.
6. rst_n asserted during WRITE beat 2 -> outputs 0 asynchronously, state IDLE, next single write completes normally.
